// File: rtl/usb_packet_transmitter_pkg.sv
// usb_packet_transmitter_pkg: shared USB constants, FSM/line types and CRC16 helpers
package usb_packet_transmitter_pkg;
   localparam logic [3:0]  PID_ACK        = 4'b0010;
   localparam logic [3:0]  PID_NAK        = 4'b1010;
   localparam logic [3:0]  PID_STALL      = 4'b1110;
   localparam logic [3:0]  PID_DATA0      = 4'b0011;
   localparam logic [3:0]  PID_DATA1      = 4'b1011;
   localparam logic [15:0] CRC16_POLY     = 16'h8005;
   localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
   localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
   localparam logic [7:0]  SYNC_PATTERN   = 8'h80;
   typedef enum logic [2:0] {S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC, S_EOP, S_JBIT} tx_state_e;
   typedef enum logic [1:0] {SYM_IDLE, SYM_BIT, SYM_SE0, SYM_J} line_sym_e;
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
      return {crc[14:0], 1'b0} ^ ((crc[15] ^ b) ? CRC16_POLY : 16'h0000);
   endfunction
   function automatic logic [3:0] last_bit(input tx_state_e s);
      return s == S_CRC ? 4'd15 : s == S_EOP ? 4'd1 : s == S_JBIT ? 4'd0 : 4'd7;
   endfunction
endpackage

// File: rtl/usb_packet_transmitter_nrzi_stuffer.sv
// usb_nrzi_stuffer: NRZI line encoder with bit stuffing and SE0/J/idle drive
module usb_nrzi_stuffer
   import usb_packet_transmitter_pkg::*;
(
   input  logic      clock48,
   input  logic      reset,
   input  logic      load_i,
   input  line_sym_e sym_i,
   input  logic      bit_i,
   output logic      stall_o,
   output logic      oe_o,
   output logic      dp_o,
   output logic      dn_o
);
   logic [2:0] ones_q, ones_d;
   logic       level_q, level_d, se0_q, se0_d, oe_q, oe_d;
   assign stall_o = ones_q == 3'd6;
   assign oe_o    = oe_q;
   assign dp_o    = ~se0_q & level_q;
   assign dn_o    = ~se0_q & ~level_q;
   // at each bit strobe pick the next line state; a due stuff bit pre-empts the requested symbol
   always_comb begin
      ones_d  = ones_q;
      level_d = level_q;
      se0_d   = se0_q;
      oe_d    = oe_q;
      if (load_i && stall_o) begin
         oe_d    = 1'b1;
         se0_d   = 1'b0;
         level_d = ~level_q;
         ones_d  = 3'd0;
      end else if (load_i) begin
         oe_d    = sym_i != SYM_IDLE;
         se0_d   = sym_i == SYM_SE0;
         level_d = sym_i == SYM_BIT ? level_q ^ ~bit_i : 1'b1;
         ones_d  = (sym_i == SYM_BIT && bit_i) ? ones_q + 3'd1 : 3'd0;
      end
   end
   // line registers; reset parks the pads undriven at J
   always_ff @(posedge clock48 or posedge reset) begin
      if (reset) begin
         ones_q  <= 3'd0;
         level_q <= 1'b1;
         se0_q   <= 1'b0;
         oe_q    <= 1'b0;
      end else begin
         ones_q  <= ones_d;
         level_q <= level_d;
         se0_q   <= se0_d;
         oe_q    <= oe_d;
      end
   end
endmodule

// File: rtl/usb_packet_transmitter.sv
// usb_packet_transmitter: device-side full-speed USB handshake/DATA packet serializer
module usb_packet_transmitter
   import usb_packet_transmitter_pkg::*;
#(
   parameter int BIT_CLOCKS = 4,
   parameter int MAX_LENGTH = 1023
) (
   input  logic        clock48,
   input  logic        reset,
   input  logic        tx_start,
   input  logic [3:0]  tx_pid,
   input  logic [10:0] tx_length,
   input  logic [7:0]  tx_byte,
   input  logic        tx_byte_valid,
   output logic        tx_byte_ready,
   output logic        tx_busy,
   output logic        tx_done,
   output logic        tx_underrun,
   output logic        usb_oe,
   output logic        usb_dp_out,
   output logic        usb_dn_out
);
   localparam int CW = BIT_CLOCKS > 1 ? $clog2(BIT_CLOCKS) : 1;
   tx_state_e   state_q, state_d, byte_next;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]  bit_q, bit_d;
   logic [7:0]  sh_q, sh_d, nxt_q, nxt_d;
   logic [10:0] left_q, left_d, len_clamp;
   logic [15:0] crc_q, crc_d;
   logic        data_q, data_d, have_q, have_d, ur_q, ur_d, done_q, done_d, und_q, und_d;
   logic        accept, strobe, stall, advance, last, load, bit_val;
   line_sym_e   sym;
   assign len_clamp     = tx_length > 11'(MAX_LENGTH) ? 11'(MAX_LENGTH) : tx_length;
   assign accept        = tx_start && state_q == S_IDLE && !done_q;
   assign strobe        = state_q != S_IDLE && cnt_q == CW'(BIT_CLOCKS - 1);
   assign advance       = strobe && !stall;
   assign last          = bit_q == last_bit(state_q);
   assign load          = accept || strobe;
   assign byte_next     = have_q ? S_DATA : (ur_q || !data_q) ? S_EOP : S_CRC;
   assign tx_byte_ready = advance && (state_q == S_PID || state_q == S_DATA) && bit_q == 4'd6 && left_q != 11'd0;
   assign tx_busy       = state_q != S_IDLE;
   assign tx_done       = done_q;
   assign tx_underrun   = und_q;
   assign sym           = state_d == S_EOP ? SYM_SE0 : state_d == S_JBIT ? SYM_J : state_d == S_IDLE ? SYM_IDLE : SYM_BIT;
   // packet sequencing, byte fetch and CRC; the next line bit is derived from the next state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      nxt_d   = nxt_q;
      left_d  = left_q;
      crc_d   = crc_q;
      data_d  = data_q;
      have_d  = have_q;
      ur_d    = ur_q;
      done_d  = advance && state_q == S_JBIT;
      und_d   = advance && state_q == S_JBIT && ur_q;
      if (accept) begin
         state_d = S_SYNC;
         cnt_d   = '0;
         bit_d   = 4'd0;
         sh_d    = {~tx_pid, tx_pid};
         data_d  = tx_pid[1:0] == 2'b11;
         left_d  = tx_pid[1:0] == 2'b11 ? len_clamp : 11'd0;
         crc_d   = CRC16_INIT;
         have_d  = 1'b0;
         ur_d    = 1'b0;
      end else if (state_q != S_IDLE) begin
         cnt_d = strobe ? '0 : cnt_q + CW'(1);
         if (tx_byte_ready && tx_byte_valid) begin
            nxt_d  = tx_byte;
            have_d = 1'b1;
            left_d = left_q - 11'd1;
         end else if (tx_byte_ready) begin
            ur_d = 1'b1;
         end
         if (advance) begin
            bit_d = last ? 4'd0 : bit_q + 4'd1;
         end
         if (advance && last) begin
            state_d = state_q == S_SYNC ? S_PID :
                      (state_q == S_PID || state_q == S_DATA) ? byte_next :
                      state_q == S_CRC ? S_EOP :
                      state_q == S_EOP ? S_JBIT : S_IDLE;
         end
         if (advance && last && have_q) begin
            sh_d   = nxt_q;
            have_d = 1'b0;
         end
      end
      bit_val = state_d == S_SYNC ? SYNC_PATTERN[bit_d[2:0]] :
                state_d == S_CRC  ? ~crc_q[4'd15 - bit_d] : sh_d[bit_d[2:0]];
      if (advance && state_d == S_DATA) begin
         crc_d = crc16_step(crc_q, bit_val);
      end
   end
   // transmitter state; async reset aborts any packet in flight
   always_ff @(posedge clock48 or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= 4'd0;
         sh_q    <= 8'd0;
         nxt_q   <= 8'd0;
         left_q  <= 11'd0;
         crc_q   <= CRC16_INIT;
         data_q  <= 1'b0;
         have_q  <= 1'b0;
         ur_q    <= 1'b0;
         done_q  <= 1'b0;
         und_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         nxt_q   <= nxt_d;
         left_q  <= left_d;
         crc_q   <= crc_d;
         data_q  <= data_d;
         have_q  <= have_d;
         ur_q    <= ur_d;
         done_q  <= done_d;
         und_q   <= und_d;
      end
   end
   usb_nrzi_stuffer u_line (
      .clock48 (clock48),
      .reset   (reset),
      .load_i  (load),
      .sym_i   (sym),
      .bit_i   (bit_val),
      .stall_o (stall),
      .oe_o    (usb_oe),
      .dp_o    (usb_dp_out),
      .dn_o    (usb_dn_out)
   );
endmodule

// File: tb/tb_usb_packet_transmitter.sv
// tb_usb_packet_transmitter: directed checks of the USB packet serializer via a line decoder
module tb_usb_packet_transmitter;
   import usb_packet_transmitter_pkg::*;
   logic        clk = 1'b0;
   logic        reset, tx_start, tx_byte_valid;
   logic [3:0]  tx_pid;
   logic [10:0] tx_length;
   logic [7:0]  tx_byte;
   logic        tx_byte_ready, tx_busy, tx_done, tx_underrun, usb_oe, usb_dp_out, usb_dn_out;
   int total = 0;
   int bad = 0;
   logic [7:0] bytes [8];
   logic [1:0] lines [$];
   bit         bits [$];
   int         dbytes [$];
   int         stuff_pos [$];
   int nready, und_cnt, und_at_done, done_cyc, coinc_busy;
   int se0_n, j_n, stuff_err, hold_err, sync_b;
   logic [15:0] resid;

   always #5 clk = ~clk;

   usb_packet_transmitter dut (
      .clock48       (clk),
      .reset         (reset),
      .tx_start      (tx_start),
      .tx_pid        (tx_pid),
      .tx_length     (tx_length),
      .tx_byte       (tx_byte),
      .tx_byte_valid (tx_byte_valid),
      .tx_byte_ready (tx_byte_ready),
      .tx_busy       (tx_busy),
      .tx_done       (tx_done),
      .tx_underrun   (tx_underrun),
      .usb_oe        (usb_oe),
      .usb_dp_out    (usb_dp_out),
      .usb_dn_out    (usb_dn_out)
   );

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int byte_at(input int i);
      return i < dbytes.size() ? dbytes[i] : -1;
   endfunction

   task automatic send(input logic [3:0] pid, input int len, input int nvalid, input int poke, input int rst_cyc, input bit coinc);
      int idx;
      bit pend;
      idx = 0;
      pend = 0;
      lines.delete();
      nready = 0;
      und_cnt = 0;
      und_at_done = 0;
      done_cyc = -1;
      coinc_busy = -1;
      tx_pid = pid;
      tx_length = 11'(len);
      tx_byte = bytes[0];
      tx_byte_valid = nvalid > 0;
      tx_start = 1'b1;
      @(negedge clk);
      for (int cyc = 1; cyc <= 2000; cyc++) begin
         tx_start = cyc == poke;
         if (pend) begin
            idx++;
            pend = 0;
         end
         tx_byte = bytes[idx & 7];
         tx_byte_valid = idx < nvalid;
         if (tx_byte_ready) begin
            nready++;
            pend = tx_byte_valid;
         end
         if (usb_oe) lines.push_back({usb_dp_out, usb_dn_out});
         if (tx_underrun) und_cnt++;
         if (cyc == rst_cyc) begin
            tx_start = 1'b0;
            return;
         end
         if (tx_done) begin
            done_cyc = cyc;
            und_at_done = tx_underrun;
            if (coinc) begin
               tx_start = 1'b1;
               @(negedge clk);
               tx_start = 1'b0;
               coinc_busy = tx_busy;
            end
            tx_start = 1'b0;
            return;
         end
         @(negedge clk);
      end
      tx_start = 1'b0;
   endtask

   task automatic decode();
      logic [1:0] lvl;
      logic [1:0] s;
      int ones;
      bit b;
      int v;
      bit fb;
      lvl = 2'b10;
      ones = 0;
      bits.delete();
      dbytes.delete();
      stuff_pos.delete();
      se0_n = 0;
      j_n = 0;
      stuff_err = 0;
      hold_err = lines.size() % 4 != 0;
      for (int k = 0; k + 3 < lines.size(); k += 4) begin
         for (int m = 1; m < 4; m++) if (lines[k+m] != lines[k]) hold_err++;
         s = lines[k];
         if (s == 2'b00) se0_n++;
         else if (se0_n > 0) j_n += int'(s == 2'b10);
         else begin
            b = s == lvl;
            lvl = s;
            if (ones == 6) begin
               stuff_pos.push_back(bits.size());
               if (b) stuff_err++;
               ones = 0;
            end else begin
               ones = b ? ones + 1 : 0;
               bits.push_back(b);
            end
         end
      end
      sync_b = -1;
      if (bits.size() >= 8) begin
         sync_b = 0;
         for (int i = 0; i < 8; i++) sync_b |= int'(bits[i]) << i;
      end
      for (int i = 8; i + 7 < bits.size(); i += 8) begin
         v = 0;
         for (int j = 0; j < 8; j++) v |= int'(bits[i+j]) << j;
         dbytes.push_back(v);
      end
      resid = 16'hFFFF;
      for (int i = 16; i < bits.size(); i++) begin
         fb = resid[15] ^ bits[i];
         resid = {resid[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
      end
   endtask

   initial begin
      reset = 1'b1;
      tx_start = 1'b0;
      tx_pid = 4'd0;
      tx_length = 11'd0;
      tx_byte = 8'd0;
      tx_byte_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_oe", usb_oe, 0);
      check("rst_dp", usb_dp_out, 1);
      check("rst_dn", usb_dn_out, 0);
      check("rst_busy", tx_busy, 0);
      check("rst_done", tx_done, 0);
      check("rst_underrun", tx_underrun, 0);
      check("rst_ready", tx_byte_ready, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      send(PID_ACK, 0, 0, -1, -1, 1'b0);
      decode();
      check("ack_done_cyc", done_cyc, 77);
      check("ack_sync", sync_b, 8'h80);
      check("ack_nbytes", dbytes.size(), 1);
      check("ack_pid", byte_at(0), 8'hD2);
      check("ack_se0", se0_n, 2);
      check("ack_j", j_n, 1);
      check("ack_ready", nready, 0);
      check("ack_hold", hold_err, 0);
      check("ack_oe_after", usb_oe, 0);
      repeat (3) @(negedge clk);

      send(PID_DATA1, 0, 0, -1, -1, 1'b0);
      decode();
      check("d1z_done_cyc", done_cyc, 141);
      check("d1z_nbytes", dbytes.size(), 3);
      check("d1z_pid", byte_at(0), 8'h4B);
      check("d1z_crc_lo", byte_at(1), 8'h00);
      check("d1z_crc_hi", byte_at(2), 8'h00);
      check("d1z_resid", resid, 16'h800D);
      check("d1z_ready", nready, 0);
      check("d1z_hold", hold_err, 0);
      repeat (3) @(negedge clk);

      bytes[0] = 8'h01;
      send(PID_DATA1, 1, 1, -1, -1, 1'b0);
      decode();
      check("d1o_nbytes", dbytes.size(), 4);
      check("d1o_pid", byte_at(0), 8'h4B);
      check("d1o_byte", byte_at(1), 8'h01);
      check("d1o_resid", resid, 16'h800D);
      check("d1o_ready", nready, 1);
      check("d1o_underrun", und_cnt, 0);
      repeat (3) @(negedge clk);

      bytes[0] = 8'hFF;
      bytes[1] = 8'hFF;
      bytes[2] = 8'hFF;
      send(PID_DATA0, 3, 3, -1, -1, 1'b0);
      decode();
      check("ff_nbytes", dbytes.size(), 6);
      check("ff_pid", byte_at(0), 8'hC3);
      check("ff_b0", byte_at(1), 8'hFF);
      check("ff_b1", byte_at(2), 8'hFF);
      check("ff_b2", byte_at(3), 8'hFF);
      check("ff_resid", resid, 16'h800D);
      check("ff_stuff_err", stuff_err, 0);
      for (int i = 0; i < 4; i++)
         check($sformatf("ff_stuff_pos%0d", i), i < stuff_pos.size() ? stuff_pos[i] : -1, 20 + 6 * i);
      check("ff_ready", nready, 3);
      check("ff_se0", se0_n, 2);
      repeat (3) @(negedge clk);

      bytes[0] = 8'h12;
      bytes[1] = 8'h34;
      send(PID_DATA0, 4, 2, 50, -1, 1'b0);
      decode();
      check("ur_nbytes", dbytes.size(), 3);
      check("ur_pid", byte_at(0), 8'hC3);
      check("ur_b0", byte_at(1), 8'h12);
      check("ur_b1", byte_at(2), 8'h34);
      check("ur_se0", se0_n, 2);
      check("ur_j", j_n, 1);
      check("ur_with_done", und_at_done, 1);
      check("ur_pulses", und_cnt, 1);
      check("ur_ready", nready, 3);
      check("ur_done_seen", done_cyc > 0, 1);
      repeat (8) @(negedge clk);
      check("ur_poke_ignored", tx_busy, 0);

      bytes[0] = 8'hAA;
      bytes[1] = 8'h55;
      send(PID_DATA1, 2, 2, -1, 100, 1'b0);
      check("mid_oe_before", usb_oe, 1);
      check("mid_busy_before", tx_busy, 1);
      reset = 1'b1;
      #1;
      check("mid_rst_oe", usb_oe, 0);
      check("mid_rst_dp", usb_dp_out, 1);
      check("mid_rst_dn", usb_dn_out, 0);
      check("mid_rst_busy", tx_busy, 0);
      check("mid_rst_ready", tx_byte_ready, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      send(PID_ACK, 0, 0, -1, -1, 1'b1);
      decode();
      check("ack2_done_cyc", done_cyc, 77);
      check("ack2_nbytes", dbytes.size(), 1);
      check("ack2_pid", byte_at(0), 8'hD2);
      check("ack2_se0", se0_n, 2);
      check("ack2_coinc_busy", coinc_busy, 0);
      repeat (4) @(negedge clk);
      check("ack2_idle_oe", usb_oe, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
